// File: rtl/qlinear_pkg.sv
// qlinear_pkg: shared FSM encoding and the round/saturate helper
// used by the quantised linear engine and its MAC lanes.
package qlinear_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  // Rounding and clipping run at this width so the +half term
  // can never wrap, whatever accumulator width the lane uses.
  localparam int WIDE = 64;

  typedef struct packed {
    logic [WIDE-1:0] val;
    logic            clip;
  } sat_t;

  // Round half up at the binary point, then clip to a signed
  // dw-bit range; clip flags that the clamp changed the value.
  function automatic sat_t round_sat(
    input logic signed [WIDE-1:0] a,
    input int                     frac,
    input int                     dw
  );
    sat_t s;
    logic signed [WIDE-1:0] half;
    logic signed [WIDE-1:0] r;
    logic signed [WIDE-1:0] hi;
    logic signed [WIDE-1:0] lo;
    half = (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
    r    = (a + half) >>> frac;
    hi   = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo   = ~hi;
    s.clip = (r > hi) || (r < lo);
    if (r > hi)      s.val = hi;
    else if (r < lo) s.val = lo;
    else             s.val = r;
    return s;
  endfunction

endpackage

// File: rtl/qmac_lane.sv
// qmac_lane: one output accumulator. Ports: load_i preloads the bias,
// mac_i accumulates w_i*x_i, fin_i rounds/saturates/ReLUs into y_o, sat_o.
module qmac_lane
  import qlinear_pkg::*;
#(
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int ACC  = 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 mac_i,
  input  logic                 fin_i,
  input  logic                 relu_i,
  input  logic signed [DW-1:0] bias_i,
  input  logic signed [DW-1:0] w_i,
  input  logic signed [DW-1:0] x_i,
  output logic        [DW-1:0] y_o,
  output logic                 sat_o
);

  logic signed [ACC-1:0]  acc_q, acc_d;
  logic signed [2*DW-1:0] prod;
  logic signed [ACC-1:0]  prod_ext;
  logic signed [ACC-1:0]  bias_ext;
  logic signed [WIDE-1:0] acc_wide;
  logic        [DW-1:0]   y_q, y_d;
  logic                   sat_q, sat_d;
  sat_t                   rs;

  assign prod     = w_i * x_i;
  assign prod_ext = {{(ACC-2*DW){prod[2*DW-1]}}, prod};
  assign bias_ext = {{(ACC-DW){bias_i[DW-1]}}, bias_i} <<< FRAC;
  assign acc_wide = {{(WIDE-ACC){acc_q[ACC-1]}}, acc_q};
  assign rs       = round_sat(acc_wide, FRAC, DW);

  always_comb begin
    acc_d = acc_q;
    if (load_i)     acc_d = bias_ext;
    else if (mac_i) acc_d = acc_q + prod_ext;
  end

  // Saturation is flagged before ReLU, so a clipped negative
  // still reports out_sat even though it reads back as 0.
  always_comb begin
    y_d   = y_q;
    sat_d = sat_q;
    if (fin_i) begin
      y_d   = rs.val[DW-1:0];
      sat_d = rs.clip;
      if (relu_i && rs.val[WIDE-1]) y_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      y_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      y_q   <= y_d;
      sat_q <= sat_d;
    end
  end

  assign y_o   = y_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/qlinear_engine.sv
// qlinear_engine: y = sat(round(W*x + b)) with optional ReLU.
// Weight/bias write ports, valid/ready input and output, busy flag.
module qlinear_engine
  import qlinear_pkg::*;
#(
  parameter int IN_DIM     = 4,
  parameter int OUT_DIM    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           w_we,
  input  logic [(OUT_DIM>1 ? $clog2(OUT_DIM) : 1)-1:0] w_row,
  input  logic [(IN_DIM>1 ? $clog2(IN_DIM) : 1)-1:0]   w_col,
  input  logic [DATA_WIDTH-1:0]          w_data,
  input  logic                           b_we,
  input  logic [(OUT_DIM>1 ? $clog2(OUT_DIM) : 1)-1:0] b_idx,
  input  logic [DATA_WIDTH-1:0]          b_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_DIM*DATA_WIDTH-1:0]   x_in,
  input  logic                           relu_en,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_DIM*DATA_WIDTH-1:0]  y_out,
  output logic [OUT_DIM-1:0]             out_sat,
  output logic                           busy
);

  localparam int KW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int DW = DATA_WIDTH;

  logic [1:0]             state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [IN_DIM*DW-1:0]   x_q;
  logic                   relu_q;
  logic [DW-1:0]          w_q [OUT_DIM][IN_DIM];
  logic [DW-1:0]          b_q [OUT_DIM];
  logic [DW-1:0]          xk;
  logic                   idle, accept, last_k;
  logic                   mac_en, fin_en;

  assign idle   = (state_q == S_IDLE);
  // rst_n is folded in so in_ready is low while reset is held.
  assign in_ready = rst_n & idle & ~w_we & ~b_we;
  assign accept = in_valid & in_ready;
  assign last_k = (k_q == KW'(IN_DIM - 1));
  assign mac_en = (state_q == S_MAC);
  assign fin_en = (state_q == S_FINAL);
  assign xk     = x_q[k_q*DW +: DW];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_MAC;
          k_d     = '0;
        end
      end
      S_MAC: begin
        k_d = k_q + 1'b1;
        if (last_k) state_d = S_FINAL;
      end
      S_FINAL: state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      x_q     <= '0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (accept) begin
        x_q    <= x_in;
        relu_q <= relu_en;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < OUT_DIM; o++) begin
        b_q[o] <= '0;
        for (int i = 0; i < IN_DIM; i++) w_q[o][i] <= '0;
      end
    end else if (idle) begin
      if (w_we) w_q[w_row][w_col] <= w_data;
      if (b_we) b_q[b_idx] <= b_data;
    end
  end

  for (genvar o = 0; o < OUT_DIM; o++) begin : g_lane
    qmac_lane #(
      .DW   (DW),
      .FRAC (FRAC_BITS),
      .ACC  (ACC_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (accept),
      .mac_i  (mac_en),
      .fin_i  (fin_en),
      .relu_i (relu_q),
      .bias_i (b_q[o]),
      .w_i    (w_q[o][k_q]),
      .x_i    (xk),
      .y_o    (y_out[o*DW +: DW]),
      .sat_o  (out_sat[o])
    );
  end

  assign out_valid = (state_q == S_OUT);
  assign busy      = ~idle;

endmodule

// File: tb/tb_qlinear_engine.sv
// tb_qlinear_engine: randomized + directed stimulus, reference model
// and scoreboard queue for qlinear_engine at default parameters.
module tb_qlinear_engine;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_we = 1'b0;
  logic [1:0]    w_row = '0;
  logic [1:0]    w_col = '0;
  logic [15:0]   w_data = '0;
  logic          b_we = 1'b0;
  logic [1:0]    b_idx = '0;
  logic [15:0]   b_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   x_in = '0;
  logic          relu_en = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [63:0]   y_out;
  logic [3:0]    out_sat;
  logic          busy;

  qlinear_engine dut (
    .clk(clk), .rst_n(rst_n),
    .w_we(w_we), .w_row(w_row), .w_col(w_col), .w_data(w_data),
    .b_we(b_we), .b_idx(b_idx), .b_data(b_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .y_out(y_out), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] y;
    logic [3:0]  sat;
  } exp_t;

  exp_t q[$];
  int   Wm [N][N];
  int   Bm [N];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   prev_ov = 0;
  bit   rnd_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // y = clamp(floor((bias*256 + sum W*x + 128) / 256)), then ReLU
  function automatic exp_t model(input logic [63:0] x, input bit relu);
    exp_t   e;
    longint acc, r;
    int     xi;
    e.y = '0;
    e.sat = '0;
    for (int o = 0; o < N; o++) begin
      acc = longint'(Bm[o]) * 256;
      for (int i = 0; i < N; i++) begin
        xi = int'($signed(x[i*DW +: DW]));
        acc += longint'(Wm[o][i]) * longint'(xi);
      end
      r = (acc + 128) >>> 8;
      if (r > 32767) begin r = 32767; e.sat[o] = 1'b1; end
      else if (r < -32768) begin r = -32768; e.sat[o] = 1'b1; end
      if (relu && r < 0) r = 0;
      e.y[o*DW +: DW] = 16'(r);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 0;
    end else begin
      if (out_valid && !prev_ov) begin
        checks++;
        if (cyc - acc_cyc != 5) begin
          errors++;
          $display("FAIL latency got %0d want 5", cyc - acc_cyc);
        end
      end
      if (out_valid) begin
        checks++;
        if (in_ready) begin
          errors++;
          $display("FAIL in_ready_in_out got 1 want 0");
        end
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out y=%h", y_out);
        end else begin
          if (y_out !== q[0].y || out_sat !== q[0].sat) begin
            errors++;
            $display("FAIL result y=%h sat=%b want y=%h sat=%b",
                     y_out, out_sat, q[0].y, q[0].sat);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic wr_w(input int r, input int c, input logic [15:0] d);
    @(negedge clk);
    w_we = 1'b1; w_row = 2'(r); w_col = 2'(c); w_data = d;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL in_ready_on_write got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    w_we = 1'b0;
    Wm[r][c] = int'($signed(d));
  endtask

  task automatic wr_b(input int r, input logic [15:0] d);
    @(negedge clk);
    b_we = 1'b1; b_idx = 2'(r); b_data = d;
    @(posedge clk); #1;
    b_we = 1'b0;
    Bm[r] = int'($signed(d));
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout busy=%b want 0", busy);
    end
  endtask

  task automatic issue(input logic [63:0] x, input bit relu, input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b want 1", in_ready);
    end else begin
      in_valid = 1'b1; x_in = x; relu_en = relu;
      if (push) q.push_back(model(x, relu));
      @(posedge clk); #1;
      acc_cyc = cyc;
      in_valid = 1'b0;
    end
  endtask

  task automatic set_diag(input int v);
    for (int o = 0; o < N; o++)
      for (int i = 0; i < N; i++)
        wr_w(o, i, (o == i) ? 16'(v) : 16'h0000);
  endtask

  task automatic set_bias(input int v);
    for (int o = 0; o < N; o++) wr_b(o, 16'(v));
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  logic [63:0] xv;
  int          n;

  initial begin
    for (int o = 0; o < N; o++) begin
      Bm[o] = 0;
      for (int i = 0; i < N; i++) Wm[o][i] = 0;
    end
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y", y_out, 64'd0);
    chk("rst_sat", 64'(out_sat), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    xv = {16'd1024, 16'd768, 16'd512, 16'd256};
    set_diag(256);
    issue(xv, 1'b0, 1'b1);
    wait_idle();
    set_bias(128);
    issue(xv, 1'b0, 1'b1);
    wait_idle();
    set_bias(0);
    wr_w(0, 0, 16'd128);
    issue({16'd1024, 16'd768, 16'd512, 16'd1}, 1'b0, 1'b1);
    wait_idle();

    for (int i = 0; i < N; i++) wr_w(0, i, 16'h7FFF);
    issue({4{16'h7FFF}}, 1'b0, 1'b1);
    wait_idle();
    for (int i = 0; i < N; i++) wr_w(0, i, 16'h8001);
    issue({4{16'h7FFF}}, 1'b0, 1'b1);
    wait_idle();

    set_diag(-256);
    issue(xv, 1'b0, 1'b1);
    wait_idle();
    issue(xv, 1'b1, 1'b1);
    wait_idle();

    // stall: output held, extra inputs and writes must be ignored
    @(posedge clk); #1 out_ready = 1'b0;
    issue(xv, 1'b0, 1'b1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("stall_valid", 64'(out_valid), 64'd1);
    repeat (10) begin
      @(posedge clk); #1;
      in_valid = 1'b1; x_in = {$urandom, $urandom};
      w_we = 1'b1; w_row = 2'($urandom); w_col = 2'($urandom);
      w_data = 16'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; w_we = 1'b0; out_ready = 1'b1;
    wait_idle();
    issue(xv, 1'b0, 1'b1);
    wait_idle();

    rnd_rdy = 1;
    for (int t = 0; t < 16; t++) begin
      wait_idle();
      if (t % 4 == 0) begin
        for (int o = 0; o < N; o++) begin
          for (int i = 0; i < N; i++)
            wr_w(o, i, (t == 8) ? 16'($urandom)
                                : 16'($urandom_range(0, 1023) - 512));
          wr_b(o, 16'($urandom_range(0, 4095) - 2048));
        end
      end
      for (int i = 0; i < N; i++)
        xv[i*DW +: DW] = (t % 3 == 0) ? 16'($urandom)
                                      : 16'($urandom_range(0, 2047) - 1024);
      issue(xv, 1'($urandom_range(0, 1)), 1'b1);
    end
    rnd_rdy = 0;
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle();

    // reset mid-MAC discards the run and clears all weights
    issue({4{16'h0100}}, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    for (int o = 0; o < N; o++) begin
      Bm[o] = 0;
      for (int i = 0; i < N; i++) Wm[o][i] = 0;
    end
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    issue({$urandom, $urandom}, 1'b0, 1'b1);
    wait_idle();
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
